// File: rtl/dfir_sched_pkg.sv
// Shared constants for the DFIR multichannel input scheduler.
package dfir_sched_pkg;

  localparam int CHIDX_W    = 4;
  localparam int MAX_CH     = 16;
  localparam int DROP_CNT_W = 16;

  // Number of set bits in a channel vector (used by the optional drop counter)
  function automatic logic [CHIDX_W:0] popCnt(input logic [MAX_CH-1:0] v);
    popCnt = '0;
    for (int i = 0; i < MAX_CH; i++)
      popCnt = popCnt + {{CHIDX_W{1'b0}}, v[i]};
  endfunction

endpackage

// File: rtl/dfir_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after lastGnt
// wins, wrapping around to channel 0.
module dfir_rr_arbiter
  import dfir_sched_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CHIDX_W-1:0] lastGnt,
  output logic [CHIDX_W-1:0] gntIdx,
  output logic               gntVld
);

  // Two constant-index passes (above lastGnt, then wrap) so no variable
  // index wider than the request vector is needed.
  always_comb begin
    gntIdx = '0;
    gntVld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gntVld && req[i] && (i > int'(lastGnt))) begin
        gntVld = 1'b1;
        gntIdx = CHIDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gntVld && req[i] && (i <= int'(lastGnt))) begin
        gntVld = 1'b1;
        gntIdx = CHIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dfir_ch_sched.sv
// Multichannel input scheduler in front of the DFIR datapath: one holding
// register per channel, round-robin issue with a minimum spacing between
// issues, and sticky overrun flags.
// Optional feature: define DFIR_SCHED_DROP_CNT_EN to add the saturating
// Drop_Cnt output (total dropped samples across channels).
module dfir_ch_sched
  import dfir_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_CH     = 2,
  parameter int MIN_GAP    = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Ch_Data_In,
  input  logic [NUM_CH-1:0]            Ch_Valid_In,
  input  logic                         Enable,
  input  logic                         Ovf_Clr,
  output logic [DATA_WIDTH-1:0]        Data_Out,
  output logic                         Data_Out_Valid,
  output logic [CHIDX_W-1:0]           Data_Out_ChIdx,
  output logic [NUM_CH-1:0]            Ovf_Flags,
  output logic                         Busy
`ifdef DFIR_SCHED_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]        Drop_Cnt
`endif
);

  localparam int                 GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [CHIDX_W-1:0] LAST_RST = CHIDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0][DATA_WIDTH-1:0] holdQ;
  logic [NUM_CH-1:0]                 pendQ;
  logic [GAP_W-1:0]                  gapCnt;
  logic [CHIDX_W-1:0]                lastGnt;
  logic [CHIDX_W-1:0]                gntIdx;
  logic                              gntVld;
  logic                              issue;
  logic [NUM_CH-1:0]                 issueVec;
  logic [NUM_CH-1:0]                 captVec;
  logic [NUM_CH-1:0]                 ovrVec;
  logic [DATA_WIDTH-1:0]             issData;

  dfir_rr_arbiter #(.NUM_CH(NUM_CH)) uArb (
    .req    (pendQ),
    .lastGnt(lastGnt),
    .gntIdx (gntIdx),
    .gntVld (gntVld)
  );

  assign issue = Enable && (gapCnt == '0) && gntVld;

  // One-hot of the channel being issued this cycle, plus its held sample
  always_comb begin
    issueVec = '0;
    issData  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gntIdx == CHIDX_W'(i)) begin
        issueVec[i] = issue;
        issData     = holdQ[i];
      end
    end
  end

  // A strobe on an empty slot, or on the slot being issued, is accepted;
  // a strobe on an occupied slot not being drained is an overrun.
  assign captVec = Ch_Valid_In & (~pendQ | issueVec);
  assign ovrVec  = Ch_Valid_In & pendQ & ~issueVec;
  assign Busy    = (|pendQ) || (gapCnt != '0);

  // Per-channel holding registers and pending bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      holdQ <= '0;
      pendQ <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (captVec[i]) holdQ[i] <= Ch_Data_In[i*DATA_WIDTH +: DATA_WIDTH];
      pendQ <= Ch_Valid_In | (pendQ & ~issueVec);
    end
  end

  // Issue registers, round-robin pointer and gap countdown
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      Data_Out       <= '0;
      Data_Out_Valid <= 1'b0;
      Data_Out_ChIdx <= '0;
      lastGnt        <= LAST_RST;
      gapCnt         <= '0;
    end else begin
      Data_Out_Valid <= issue;
      if (issue) begin
        Data_Out       <= issData;
        Data_Out_ChIdx <= gntIdx;
        lastGnt        <= gntIdx;
        gapCnt         <= GAP_LOAD;
      end else if (gapCnt != '0) begin
        gapCnt <= gapCnt - GAP_W'(1);
      end
    end
  end

  // Sticky overrun flags; a fresh overrun beats a simultaneous clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) Ovf_Flags <= '0;
    else       Ovf_Flags <= (Ovf_Clr ? '0 : Ovf_Flags) | ovrVec;
  end

`ifdef DFIR_SCHED_DROP_CNT_EN
  localparam int DSUM_W = DROP_CNT_W + 1;

  logic [DROP_CNT_W-1:0] dropBase;
  logic [DSUM_W-1:0]     dropSum;

  assign dropBase = Ovf_Clr ? '0 : Drop_Cnt;
  assign dropSum  = {1'b0, dropBase} + DSUM_W'(popCnt(MAX_CH'(ovrVec)));

  // Saturating total of dropped samples; clear restarts from this cycle's drops
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) Drop_Cnt <= '0;
    else       Drop_Cnt <= dropSum[DROP_CNT_W] ? '1 : dropSum[DROP_CNT_W-1:0];
  end
`endif

endmodule
